// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes host commands, sequences SPI/EEPROM/DAC frames and gain/offset-corrects dump samples.
// Defining CMD_TIMEOUT_EN adds an SPI watchdog that NACKs a transaction whose SPI_done never arrives.
module cmd_dispatch #(
    parameter int NUM_CH      = 3,
    parameter int TPOS_W      = 9,
    parameter int DEC_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       cmd,
    input  logic              cmd_rdy,
    output logic              clr_cmd_rdy,
    output logic [7:0]        resp_data,
    output logic              send_resp,
    output logic [NUM_CH+1:0] ss,
    output logic              wrt_SPI,
    output logic [15:0]       SPI_data,
    input  logic [7:0]        EEP_data,
    input  logic              SPI_done,
    output logic              start_dump,
    output logic [1:0]        dump_channel,
    input  logic [7:0]        dump_data,
    input  logic              send_dump,
    input  logic              dump_finished,
    input  logic              set_capture_done,
    output logic [5:0]        trig_cfg,
    output logic [DEC_W-1:0]  decimator,
    output logic [TPOS_W-1:0] trig_pos
);
    localparam int SS_W = NUM_CH + 2;
    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;

    typedef enum logic [2:0] {IDLE, WRT, RD0, RD1, RD2, DUMP_FETCH, DUMP_RUN} state_t;
    typedef enum logic [1:0] {FT_READ, FT_OFFSET, FT_GAIN} fetch_t;

    state_t            state_q, state_d;
    fetch_t            fetch_q, fetch_d;
    logic [5:0]        addr_q, addr_d;
    logic [SS_W-1:0]   ss_q, ss_d;
    logic [1:0]        dump_channel_q, dump_channel_d;
    logic [3:0][2:0]   ggg_q, ggg_d;
    logic signed [7:0] offset_q, offset_d;
    logic [7:0]        gain_q, gain_d;
    logic [5:0]        trig_cfg_q, trig_cfg_d;
    logic [DEC_W-1:0]  decimator_q, decimator_d;
    logic [TPOS_W-1:0] trig_pos_q, trig_pos_d;

    logic [3:0] opcode;
    logic [1:0] cmd_ch;
    logic [2:0] cmd_ggg;
    logic       ch_bad;
    logic [5:0] off_addr;
    logic [5:0] gain_addr;
    logic       unused_cmd;

    assign opcode     = cmd[19:16];
    assign cmd_ch     = cmd[9:8];
    assign cmd_ggg    = cmd[12:10];
    assign ch_bad     = (int'(cmd_ch) >= NUM_CH);
    assign off_addr   = {cmd_ch, ggg_q[cmd_ch], 1'b0};
    assign gain_addr  = {dump_channel_q, ggg_q[dump_channel_q], 1'b1};
    assign unused_cmd = ^{cmd[23:20], cmd[15:14]};

    function automatic logic [7:0] gain_lut(input logic [2:0] code);
        case (code)
            3'd0:    return 8'h02;
            3'd1:    return 8'h05;
            3'd2:    return 8'h09;
            3'd3:    return 8'h14;
            3'd4:    return 8'h28;
            3'd5:    return 8'h46;
            3'd6:    return 8'h6B;
            default: return 8'hDD;
        endcase
    endfunction

    function automatic logic [15:0] rd_frame(input logic [5:0] a);
        return {2'b00, a, 8'h00};
    endfunction

    // Raw sample plus signed EEPROM offset, clamped to the unsigned byte range.
    function automatic logic [7:0] sat_offset(input logic [7:0] d, input logic signed [7:0] off);
        logic signed [9:0] s;
        s = $signed({2'b00, d}) + $signed({{2{off[7]}}, off});
        if (s < 0)
            return 8'h00;
        else if (s > 10'sd255)
            return 8'hFF;
        else
            return s[7:0];
    endfunction

    // Gain is Q1.7: scale by gain/128 and saturate at full scale.
    function automatic logic [7:0] scale_sat(input logic [7:0] s, input logic [7:0] g);
        logic [15:0] p;
        p = ({8'h00, s} * {8'h00, g}) >> 7;
        if (p > 16'd255)
            return 8'hFF;
        else
            return p[7:0];
    endfunction

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             waiting;
    logic             tmo_hit;

    assign waiting = (state_q == WRT) || (state_q == RD0) || (state_q == RD1) || (state_q == RD2);
    assign tmo_hit = waiting && !SPI_done && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (wrt_SPI)
            tmo_d = '0;
        else if (waiting)
            tmo_d = tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

    always_comb begin
        state_d        = state_q;
        fetch_d        = fetch_q;
        addr_d         = addr_q;
        ss_d           = ss_q;
        dump_channel_d = dump_channel_q;
        ggg_d          = ggg_q;
        offset_d       = offset_q;
        gain_d         = gain_q;
        trig_cfg_d     = trig_cfg_q;
        decimator_d    = decimator_q;
        trig_pos_d     = trig_pos_q;
        clr_cmd_rdy    = 1'b0;
        send_resp      = 1'b0;
        resp_data      = '0;
        wrt_SPI        = 1'b0;
        SPI_data       = '0;
        start_dump     = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    case (opcode)
                        4'h1: if (ch_bad) begin
                            send_resp = 1'b1;
                            resp_data = NACK;
                        end else begin
                            dump_channel_d = cmd_ch;
                            addr_d         = off_addr;
                            fetch_d        = FT_OFFSET;
                            wrt_SPI        = 1'b1;
                            SPI_data       = rd_frame(off_addr);
                            ss_d           = SS_W'(1);
                            state_d        = RD0;
                        end
                        4'h2: if (ch_bad) begin
                            send_resp = 1'b1;
                            resp_data = NACK;
                        end else begin
                            ggg_d[cmd_ch] = cmd_ggg;
                            wrt_SPI       = 1'b1;
                            SPI_data      = {8'h13, gain_lut(cmd_ggg)};
                            ss_d          = SS_W'(6'b000100 << cmd_ch);
                            state_d       = WRT;
                        end
                        4'h3: begin
                            wrt_SPI  = 1'b1;
                            SPI_data = {8'h13, cmd[7:0]};
                            ss_d     = SS_W'(2);
                            state_d  = WRT;
                        end
                        4'h4: begin
                            trig_pos_d = cmd[TPOS_W-1:0];
                            send_resp  = 1'b1;
                            resp_data  = ACK;
                        end
                        4'h5: begin
                            decimator_d = cmd[DEC_W-1:0];
                            send_resp   = 1'b1;
                            resp_data   = ACK;
                        end
                        4'h6: begin
                            trig_cfg_d = cmd[13:8];
                            send_resp  = 1'b1;
                            resp_data  = ACK;
                        end
                        4'h7: begin
                            send_resp = 1'b1;
                            resp_data = {2'b00, trig_cfg_q};
                        end
                        4'h8: begin
                            wrt_SPI  = 1'b1;
                            SPI_data = {2'b01, cmd[13:0]};
                            ss_d     = SS_W'(1);
                            state_d  = WRT;
                        end
                        4'h9: begin
                            addr_d   = cmd[13:8];
                            fetch_d  = FT_READ;
                            wrt_SPI  = 1'b1;
                            SPI_data = rd_frame(cmd[13:8]);
                            ss_d     = SS_W'(1);
                            state_d  = RD0;
                        end
                        default: begin
                            send_resp = 1'b1;
                            resp_data = NACK;
                        end
                    endcase
                end
                WRT: if (SPI_done) begin
                    send_resp = 1'b1;
                    resp_data = ACK;
                    ss_d      = '0;
                    state_d   = IDLE;
                end
                // EEPROM reads go address frame, deselected dummy frame, then a re-read that returns the byte.
                RD0: if (SPI_done) begin
                    wrt_SPI = 1'b1;
                    ss_d    = '0;
                    state_d = RD1;
                end
                RD1: if (SPI_done) begin
                    wrt_SPI  = 1'b1;
                    SPI_data = rd_frame(addr_q);
                    ss_d     = SS_W'(1);
                    state_d  = RD2;
                end
                RD2: if (SPI_done) begin
                    ss_d = '0;
                    case (fetch_q)
                        FT_OFFSET: begin
                            offset_d = $signed(EEP_data);
                            state_d  = DUMP_FETCH;
                        end
                        FT_GAIN: begin
                            gain_d     = EEP_data;
                            start_dump = 1'b1;
                            state_d    = DUMP_RUN;
                        end
                        default: begin
                            send_resp = 1'b1;
                            resp_data = EEP_data;
                            state_d   = IDLE;
                        end
                    endcase
                end
                DUMP_FETCH: begin
                    addr_d   = gain_addr;
                    fetch_d  = FT_GAIN;
                    wrt_SPI  = 1'b1;
                    SPI_data = rd_frame(gain_addr);
                    ss_d     = SS_W'(1);
                    state_d  = RD0;
                end
                DUMP_RUN: begin
                    if (send_dump) begin
                        send_resp = 1'b1;
                        resp_data = scale_sat(sat_offset(dump_data, offset_q), gain_q);
                    end else if (dump_finished) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

`ifdef CMD_TIMEOUT_EN
            if (tmo_hit) begin
                send_resp = 1'b1;
                resp_data = NACK;
                ss_d      = '0;
                state_d   = IDLE;
            end
`endif
        end

        trig_cfg_d[5] = trig_cfg_d[5] | set_capture_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            fetch_q        <= FT_READ;
            addr_q         <= '0;
            ss_q           <= '0;
            dump_channel_q <= '0;
            ggg_q          <= '0;
            offset_q       <= '0;
            gain_q         <= '0;
            trig_cfg_q     <= '0;
            decimator_q    <= '0;
            trig_pos_q     <= '0;
        end else begin
            state_q        <= state_d;
            fetch_q        <= fetch_d;
            addr_q         <= addr_d;
            ss_q           <= ss_d;
            dump_channel_q <= dump_channel_d;
            ggg_q          <= ggg_d;
            offset_q       <= offset_d;
            gain_q         <= gain_d;
            trig_cfg_q     <= trig_cfg_d;
            decimator_q    <= decimator_d;
            trig_pos_q     <= trig_pos_d;
        end
    end

    assign ss           = ss_q;
    assign dump_channel = dump_channel_q;
    assign trig_cfg     = trig_cfg_q;
    assign decimator    = decimator_q;
    assign trig_pos     = trig_pos_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: randomized commands against a behavioural model of the command set.
module tb_cmd_dispatch;
    localparam int NUM_CH = 3;
    localparam int SS_W   = NUM_CH + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [23:0]     cmd;
    logic            cmd_rdy;
    logic            clr_cmd_rdy;
    logic [7:0]      resp_data;
    logic            send_resp;
    logic [SS_W-1:0] ss;
    logic            wrt_SPI;
    logic [15:0]     SPI_data;
    logic [7:0]      EEP_data;
    logic            SPI_done;
    logic            start_dump;
    logic [1:0]      dump_channel;
    logic [7:0]      dump_data;
    logic            send_dump;
    logic            dump_finished;
    logic            set_capture_done;
    logic [5:0]      trig_cfg;
    logic [3:0]      decimator;
    logic [8:0]      trig_pos;

    cmd_dispatch #(.NUM_CH(NUM_CH), .TPOS_W(9), .DEC_W(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data(resp_data), .send_resp(send_resp), .ss(ss), .wrt_SPI(wrt_SPI),
        .SPI_data(SPI_data), .EEP_data(EEP_data), .SPI_done(SPI_done), .start_dump(start_dump),
        .dump_channel(dump_channel), .dump_data(dump_data), .send_dump(send_dump),
        .dump_finished(dump_finished), .set_capture_done(set_capture_done),
        .trig_cfg(trig_cfg), .decimator(decimator), .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        cap_clr, cap_send, cap_wrt, cap_start;
    logic [7:0]  cap_resp;
    logic [15:0] cap_data;

    int m_trig, m_dec, m_tpos;
    int m_ggg [4];
    int lut [8] = '{'h02, 'h05, 'h09, 'h14, 'h28, 'h46, 'h6B, 'hDD};

    function automatic int corr(int d, int off, int g);
        int s;
        s = d + ((off > 127) ? off - 256 : off);
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        s = (s * g) / 128;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture();
        cap_clr   = clr_cmd_rdy;
        cap_send  = send_resp;
        cap_resp  = resp_data;
        cap_wrt   = wrt_SPI;
        cap_data  = SPI_data;
        cap_start = start_dump;
    endtask

    task automatic issue_cmd(input logic [23:0] c);
        cmd = c;
        cmd_rdy = 1'b1;
        #1;
        capture();
        step();
        cmd_rdy = 1'b0;
        cmd = 24'($urandom);
    endtask

    task automatic spi_done(input int dly, input logic [7:0] eep);
        repeat (dly) step();
        SPI_done = 1'b1;
        EEP_data = eep;
        #1;
        capture();
        step();
        SPI_done = 1'b0;
        EEP_data = 8'($urandom);
    endtask

    task automatic model_reset();
        m_trig = 0; m_dec = 0; m_tpos = 0;
        for (int k = 0; k < 4; k++) m_ggg[k] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        model_reset();
        total++; if (ss !== '0) begin bad++; $display("FAIL reset_ss: got %b want 0", ss); end
        total++; if ({trig_cfg, decimator, trig_pos} !== '0) begin bad++; $display("FAIL reset_cfg: got %h/%h/%h want 0", trig_cfg, decimator, trig_pos); end
        total++; if (dump_channel !== 2'd0) begin bad++; $display("FAIL reset_dump_ch: got %0d want 0", dump_channel); end
        total++; if ({clr_cmd_rdy, send_resp, wrt_SPI, start_dump} !== 4'b0 || resp_data !== 8'h00 || SPI_data !== 16'h0)
            begin bad++; $display("FAIL reset_pulses: got %b resp %h spi %h want 0", {clr_cmd_rdy, send_resp, wrt_SPI, start_dump}, resp_data, SPI_data); end
        issue_cmd(24'h07_0000);
        total++; if (!(cap_clr && cap_send) || cap_resp !== 8'h00) begin bad++; $display("FAIL reset_readcfg: got clr %b send %b resp %h want 1 1 00", cap_clr, cap_send, cap_resp); end
    endtask

    task automatic test_config();
        for (int i = 0; i < 12; i++) begin
            int op;
            logic [23:0] c;
            logic [7:0] exp;
            op = 4 + int'($urandom_range(0, 3));
            c = 24'((op << 16) | int'($urandom_range(0, 65535)));
            exp = 8'hA5;
            case (op)
                4: m_tpos = int'(c) % 512;
                5: m_dec = int'(c) % 16;
                6: m_trig = (int'(c) >> 8) % 64;
                default: exp = 8'(m_trig);
            endcase
            issue_cmd(c);
            total++; if (!(cap_clr && cap_send && !cap_wrt) || cap_resp !== exp)
                begin bad++; $display("FAIL cfg_resp op%0d: got clr %b send %b resp %h want 1 1 %h", op, cap_clr, cap_send, cap_resp, exp); end
            total++; if (trig_pos !== 9'(m_tpos) || decimator !== 4'(m_dec) || trig_cfg !== 6'(m_trig))
                begin bad++; $display("FAIL cfg_regs: got %h/%h/%h want %h/%h/%h", trig_pos, decimator, trig_cfg, m_tpos, m_dec, m_trig); end
        end
    endtask

    task automatic test_capture_done();
        logic [23:0] c;
        set_capture_done = 1'b1;
        step();
        set_capture_done = 1'b0;
        m_trig = m_trig | 32;
        total++; if (trig_cfg !== 6'(m_trig)) begin bad++; $display("FAIL capdone_set: got %h want %h", trig_cfg, m_trig); end
        c = 24'h06_0000 | 24'(int'($urandom_range(0, 31)) << 8);
        set_capture_done = 1'b1;
        issue_cmd(c);
        set_capture_done = 1'b0;
        m_trig = ((int'(c) >> 8) % 64) | 32;
        total++; if (trig_cfg !== 6'(m_trig)) begin bad++; $display("FAIL capdone_collide: got %h want %h", trig_cfg, m_trig); end
        issue_cmd(c);
        m_trig = (int'(c) >> 8) % 64;
        total++; if (trig_cfg !== 6'(m_trig)) begin bad++; $display("FAIL capdone_clear: got %h want %h", trig_cfg, m_trig); end
    endtask

    task automatic test_gain();
        for (int i = 0; i < 7; i++) begin
            int ch, g;
            logic [23:0] c;
            ch = (i == 0) ? 1 : int'($urandom_range(0, NUM_CH - 1));
            g  = (i == 0) ? 2 : int'($urandom_range(0, 7));
            c = 24'((2 << 16) | (g << 10) | (ch << 8) | ((i == 0) ? 0 : int'($urandom_range(0, 255))));
            issue_cmd(c);
            total++; if (!(cap_clr && cap_wrt && !cap_send) || cap_data !== 16'('h1300 + lut[g]))
                begin bad++; $display("FAIL gain_frame: got wrt %b frame %h want 1 %h", cap_wrt, cap_data, 16'('h1300 + lut[g])); end
            total++; if (ss !== SS_W'(4 << ch) || wrt_SPI !== 1'b0)
                begin bad++; $display("FAIL gain_ss: got ss %b wrt %b want %b 0", ss, wrt_SPI, SS_W'(4 << ch)); end
            spi_done(int'($urandom_range(0, 4)), 8'h00);
            total++; if (!cap_send || cap_resp !== 8'hA5 || ss !== '0)
                begin bad++; $display("FAIL gain_ack: got send %b resp %h ss %b want 1 a5 0", cap_send, cap_resp, ss); end
            m_ggg[ch] = g;
        end
    endtask

    task automatic test_spi_write();
        for (int i = 0; i < 6; i++) begin
            int op, pay, exp_ss, exp_f;
            op = ($urandom_range(0, 1) == 1) ? 3 : 8;
            pay = int'($urandom_range(0, 16383));
            exp_ss = (op == 3) ? 2 : 1;
            exp_f = (op == 3) ? ('h1300 + pay % 256) : ('h4000 + pay);
            issue_cmd(24'((op << 16) | pay));
            total++; if (!cap_wrt || cap_data !== 16'(exp_f) || ss !== SS_W'(exp_ss))
                begin bad++; $display("FAIL write_frame op%0d: got frame %h ss %b want %h %b", op, cap_data, ss, 16'(exp_f), SS_W'(exp_ss)); end
            spi_done(int'($urandom_range(0, 3)), 8'h00);
            total++; if (!cap_send || cap_resp !== 8'hA5 || ss !== '0)
                begin bad++; $display("FAIL write_ack: got send %b resp %h ss %b want 1 a5 0", cap_send, cap_resp, ss); end
        end
    endtask

    task automatic test_eeprom_read();
        for (int i = 0; i < 5; i++) begin
            int addr;
            logic [7:0] byte_v;
            addr = (i == 0) ? 5 : int'($urandom_range(0, 63));
            byte_v = (i == 0) ? 8'h3C : 8'($urandom);
            issue_cmd(24'((9 << 16) | (addr << 8) | ((i == 0) ? 0 : int'($urandom_range(0, 255)))));
            total++; if (!cap_wrt || cap_data !== 16'(addr << 8) || ss !== SS_W'(1))
                begin bad++; $display("FAIL rd_frame0: got %h ss %b want %h 1", cap_data, ss, 16'(addr << 8)); end
            spi_done(int'($urandom_range(0, 3)), 8'($urandom));
            total++; if (!cap_wrt || cap_data !== 16'h0000 || ss !== '0 || cap_send)
                begin bad++; $display("FAIL rd_dummy: got wrt %b frame %h ss %b want 1 0000 0", cap_wrt, cap_data, ss); end
            spi_done(int'($urandom_range(0, 3)), 8'($urandom));
            total++; if (!cap_wrt || cap_data !== 16'(addr << 8) || ss !== SS_W'(1))
                begin bad++; $display("FAIL rd_reread: got %h ss %b want %h 1", cap_data, ss, 16'(addr << 8)); end
            spi_done(int'($urandom_range(0, 3)), byte_v);
            total++; if (!cap_send || cap_resp !== byte_v || cap_wrt || ss !== '0)
                begin bad++; $display("FAIL rd_resp: got send %b resp %h want 1 %h", cap_send, cap_resp, byte_v); end
        end
    endtask

    task automatic test_dump();
        for (int r = 0; r < 3; r++) begin
            int ch, g, off, gn, base;
            ch  = (r == 0) ? 0 : int'($urandom_range(0, NUM_CH - 1));
            off = (r == 0) ? 'hF6 : int'($urandom_range(0, 255));
            gn  = (r == 0) ? 'h80 : int'($urandom_range(0, 255));
            g = m_ggg[ch];
            base = ch * 16 + g * 2;
            issue_cmd(24'((1 << 16) | (ch << 8)));
            total++; if (!cap_clr || !cap_wrt || cap_data !== 16'(base << 8) || dump_channel !== 2'(ch) || ss !== SS_W'(1))
                begin bad++; $display("FAIL dump_off_addr: got frame %h ch %0d want %h %0d", cap_data, dump_channel, 16'(base << 8), ch); end
            spi_done(int'($urandom_range(0, 2)), 8'($urandom));
            spi_done(int'($urandom_range(0, 2)), 8'($urandom));
            total++; if (!cap_wrt || cap_data !== 16'(base << 8))
                begin bad++; $display("FAIL dump_off_reread: got %h want %h", cap_data, 16'(base << 8)); end
            spi_done(int'($urandom_range(0, 2)), 8'(off));
            total++; if (cap_send || cap_start || !wrt_SPI || SPI_data !== 16'((base + 1) << 8))
                begin bad++; $display("FAIL dump_gain_addr: got wrt %b frame %h want 1 %h", wrt_SPI, SPI_data, 16'((base + 1) << 8)); end
            step();
            spi_done(int'($urandom_range(0, 2)), 8'($urandom));
            spi_done(int'($urandom_range(0, 2)), 8'($urandom));
            spi_done(int'($urandom_range(0, 2)), 8'(gn));
            total++; if (!cap_start || cap_send) begin bad++; $display("FAIL dump_start: got start %b send %b want 1 0", cap_start, cap_send); end
            total++; if (start_dump !== 1'b0) begin bad++; $display("FAIL dump_start_pulse: got %b want 0", start_dump); end
            for (int j = 0; j < 6; j++) begin
                int s;
                s = (r == 0 && j < 2) ? ((j == 0) ? 'h05 : 'h64) : int'($urandom_range(0, 255));
                send_dump = 1'b1;
                dump_data = 8'(s);
                dump_finished = (j == 3);
                #1;
                total++; if (!send_resp || resp_data !== 8'(corr(s, off, gn)))
                    begin bad++; $display("FAIL dump_sample s=%h off=%h g=%h: got %b %h want 1 %h", s, off, gn, send_resp, resp_data, 8'(corr(s, off, gn))); end
                step();
                send_dump = 1'b0;
                dump_finished = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            dump_finished = 1'b1;
            #1;
            total++; if (send_resp !== 1'b0) begin bad++; $display("FAIL dump_finish_resp: got %b want 0", send_resp); end
            step();
            dump_finished = 1'b0;
            issue_cmd(24'h07_0000);
            total++; if (!cap_clr || !cap_send || cap_resp !== 8'(m_trig))
                begin bad++; $display("FAIL dump_idle: got clr %b resp %h want 1 %h", cap_clr, cap_resp, 8'(m_trig)); end
        end
    endtask

    task automatic test_nack();
        logic [23:0] list [7];
        list[0] = 24'h0F_0000;
        list[1] = 24'h00_1234;
        for (int k = 2; k < 5; k++) list[k] = 24'((int'($urandom_range(10, 14)) << 16) | int'($urandom_range(0, 65535)));
        list[5] = 24'h01_0300;
        list[6] = 24'h02_0F00;
        for (int i = 0; i < 7; i++) begin
            issue_cmd(list[i]);
            total++; if (!cap_clr || !cap_send || cap_wrt || cap_resp !== 8'hEE || ss !== '0)
                begin bad++; $display("FAIL nack %h: got clr %b send %b wrt %b resp %h want 1 1 0 ee", list[i], cap_clr, cap_send, cap_wrt, cap_resp); end
            issue_cmd(24'h07_0000);
            total++; if (!cap_send || cap_resp !== 8'(m_trig))
                begin bad++; $display("FAIL nack_idle: got send %b resp %h want 1 %h", cap_send, cap_resp, 8'(m_trig)); end
        end
    endtask

    task automatic test_reset_mid();
        issue_cmd(24'h09_1200);
        spi_done(1, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        total++; if (ss !== '0 || {clr_cmd_rdy, send_resp, wrt_SPI, start_dump} !== 4'b0 || resp_data !== 8'h00 || SPI_data !== 16'h0)
            begin bad++; $display("FAIL midrst_outputs: got ss %b pulses %b resp %h spi %h want 0", ss, {clr_cmd_rdy, send_resp, wrt_SPI, start_dump}, resp_data, SPI_data); end
        total++; if ({trig_cfg, decimator, trig_pos, dump_channel} !== '0)
            begin bad++; $display("FAIL midrst_cfg: got %h/%h/%h/%h want 0", trig_cfg, decimator, trig_pos, dump_channel); end
        spi_done(0, 8'h55);
        total++; if (cap_send || cap_wrt) begin bad++; $display("FAIL midrst_stray_done: got send %b wrt %b want 0 0", cap_send, cap_wrt); end
        issue_cmd(24'h07_0000);
        total++; if (!cap_send || cap_resp !== 8'h00) begin bad++; $display("FAIL midrst_readcfg: got send %b resp %h want 1 00", cap_send, cap_resp); end
    endtask

`ifdef CMD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        issue_cmd(24'h08_1234);
        n = 1;
        while (n <= 40 && !send_resp) begin
            step();
            n++;
        end
        total++; if (!send_resp || resp_data !== 8'hEE || n != 16)
            begin bad++; $display("FAIL timeout_nack: got send %b resp %h cycle %0d want 1 ee 16", send_resp, resp_data, n); end
        step();
        issue_cmd(24'h07_0000);
        total++; if (!cap_clr || !cap_send || cap_resp !== 8'(m_trig))
            begin bad++; $display("FAIL timeout_idle: got clr %b resp %h want 1 %h", cap_clr, cap_resp, 8'(m_trig)); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cmd = '0; cmd_rdy = 1'b0; EEP_data = '0; SPI_done = 1'b0;
        dump_data = '0; send_dump = 1'b0; dump_finished = 1'b0; set_capture_done = 1'b0;
        test_reset();
        test_config();
        test_capture_done();
        test_gain();
        test_spi_write();
        test_eeprom_read();
        test_dump();
        test_nack();
        test_reset_mid();
`ifdef CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Param NUM_CH, default 3, number of analog channels, legal range 1..4.
REQ-002 Param TPOS_W, default 9, trigger-position width.
REQ-003 Param DEC_W, default 4, decimator width.
REQ-004 Param TIMEOUT_CYC, default 4096, SPI watchdog limit in clk cycles.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cmd  in  24  command; opcode cmd[19:16], channel cmd[9:8], gain code cmd[12:10], data cmd[7:0].
REQ-008 cmd_rdy  in  1  cmd valid.
REQ-009 clr_cmd_rdy  out  1  one-cycle pulse that consumes cmd.
REQ-010 resp_data  out  8  response byte.
REQ-011 send_resp  out  1  one-cycle pulse: resp_data valid.
REQ-012 ss  out  NUM_CH+2  one-hot slave select: bit0 EEPROM, bit1 trigger DAC, bit 2+k channel k; all-zero means none.
REQ-013 wrt_SPI  out  1  one-cycle SPI start pulse.
REQ-014 SPI_data  out  16  SPI frame.
REQ-015 EEP_data  in  8  EEPROM read byte.
REQ-016 SPI_done  in  1  one-cycle SPI completion pulse.
REQ-017 start_dump  out  1  pulse to capture.
REQ-018 dump_channel  out  2  channel being dumped.
REQ-019 dump_data  in  8  raw sample; send_dump  in  1  sample valid; dump_finished  in  1  end of dump.
REQ-020 set_capture_done  in  1  sets trig_cfg[5].
REQ-021 trig_cfg  out  6; decimator  out  DEC_W; trig_pos  out  TPOS_W; registered config.

Function
REQ-022 States: IDLE, WRT, RD0, RD1, RD2, DUMP_FETCH, DUMP_RUN; a command is accepted only in IDLE with cmd_rdy, pulsing clr_cmd_rdy in the accept cycle.
REQ-023 Opcode 4 SET_TRIGPOS: trig_pos <= cmd[TPOS_W-1:0]; opcode 5 SET_DEC: decimator <= cmd[DEC_W-1:0]; opcode 6 SET_TRIG_CFG: trig_cfg <= cmd[13:8]; each sends ACK 0xA5 in the accept cycle.
REQ-024 Opcode 7 READ_TRIG_CFG sends {2'b00,trig_cfg} in the accept cycle.
REQ-025 Opcode 2 CONFIG_GAIN: stores the gain code for the channel, asserts ss bit 2+ch, and sends frame {8'h13, LUT[ggg]}, LUT = 02,05,09,14,28,46,6B,DD; enters WRT.
REQ-026 Opcode 3 SET_TRIGGER: ss bit1, frame {8'h13,cmd[7:0]}; opcode 8 WRITE_EEPROM: ss bit0, frame {2'b01,cmd[13:0]}; both enter WRT.
REQ-027 WRT: on SPI_done, send ACK and go to IDLE.
REQ-028 Opcode 9 READ_EEPROM: frame {2'b00,cmd[13:8],8'h00} to EEPROM; RD0 on done issues a dummy frame 16'h0000 with ss all-zero; RD1 on done issues a re-read frame to EEPROM; RD2 on done sends EEP_data and goes to IDLE.
REQ-029 Opcode 1 DUMP: latch dump_channel; fetch offset at addr {ch,ggg[ch],1'b0}, then gain at addr {ch,ggg[ch],1'b1}, each using the RD0..RD2 three-frame sequence; then pulse start_dump and enter DUMP_RUN.
REQ-030 DUMP_RUN: on send_dump, send corrected sample in the same cycle; on dump_finished without send_dump, go to IDLE; send_dump takes priority.
REQ-031 Correction: s = dump_data + signed offset, clamped 0..255; c = (s*gain)>>7, clamped to 255.
REQ-032 Unknown opcode, or channel >= NUM_CH on opcode 1/2: send NACK 0xEE in the accept cycle, no state change.
REQ-033 trig_cfg[5] <= set_capture_done | next value each cycle; set_capture_done and a SET_TRIG_CFG write in the same cycle yield bit5 = 1.
REQ-034 wrt_SPI, send_resp, clr_cmd_rdy and start_dump are never high for more than one consecutive cycle from the same event.

Reset
REQ-035 With rst high at a clk edge: state IDLE; every output, every gain code, offset and gain = 0; ss = 0. Reset mid-transaction aborts without a response.

Configuration
REQ-036 With CMD_TIMEOUT_EN defined, a counter restarts on each wrt_SPI; if it reaches TIMEOUT_CYC without SPI_done, NACK is sent, start_dump is suppressed and state returns to IDLE; without the macro, waits are unbounded and no counter exists.

Verification
REQ-037 cmd 0x02_0900 (ch1, ggg2) -> ss=0b01000, frame 0x1309; SPI_done -> ACK 0xA5.
REQ-038 cmd 0x09_0500, three SPI_done pulses, EEP_data 0x3C on the last -> frames 0x0500, 0x0000, re-read; response 0x3C.
REQ-039 DUMP ch0, offset 0xF6 (-10), gain 0x80, sample 0x05 -> response 0x00; sample 0x64 -> 0x5A.
REQ-040 cmd opcode 0xF, or DUMP with channel 3 at NUM_CH=3 -> NACK 0xEE, clr_cmd_rdy pulse, state IDLE.
REQ-041 CMD_TIMEOUT_EN defined, TIMEOUT_CYC=16, WRITE_EEPROM with no SPI_done -> NACK after 16 cycles; next command is accepted.
REQ-042 rst asserted in RD1 -> all outputs 0 next cycle; READ_TRIG_CFG then returns 0x00.
